// File: rtl/led_pwm_driver.sv
// Ten-channel LED PWM driver with shared brightness and blink, prescaled counter.
// Inputs are shadowed at each PWM period boundary so duty changes never glitch mid-period.
module led_pwm_driver #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned PRESCALE    = 196,
  parameter int unsigned BLINK_TICKS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          led_pattern,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blink_en,
  output logic [9:0]          led_out,
  output logic                period_start,
  output logic                blink_phase
);

  localparam logic [15:0]         PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0]         BLINK_LAST = 16'(BLINK_TICKS - 1);
  localparam logic [PWM_BITS-1:0] PWM_FULL   = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);

  logic [15:0]         presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                period_start_q, period_start_d;
  logic [9:0]          pat_sh_q, pat_sh_d;
  logic [PWM_BITS-1:0] bri_sh_q, bri_sh_d;
  logic                ben_sh_q, ben_sh_d;
  logic [15:0]         blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [9:0]          led_out_q, led_out_d;
  logic                tick;
  logic                pwm_on;

  // Counter chain: prescaler -> pwm counter -> period boundary
  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? 16'd0 : presc_q + 16'd1;
    pwm_cnt_d = tick ? pwm_cnt_q + PWM_ONE : pwm_cnt_q;
    // Registered look-ahead: high exactly on the cycle where tick=1 and pwm_cnt is all-ones
    period_start_d = (presc_d == PRESC_LAST) && (pwm_cnt_d == PWM_FULL);
  end

  // Shadow load and blink bookkeeping, both keyed to the period boundary
  always_comb begin
    pat_sh_d      = pat_sh_q;
    bri_sh_d      = bri_sh_q;
    ben_sh_d      = ben_sh_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (period_start_q) begin
      pat_sh_d = led_pattern;
      bri_sh_d = brightness;
      ben_sh_d = blink_en;
      // The freshly loaded enable decides whether this boundary counts
      if (blink_en) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d   = 16'd0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 16'd1;
        end
      end else begin
        blink_cnt_d   = 16'd0;
        blink_phase_d = 1'b0;
      end
    end
  end

  // Full-scale brightness is forced on so all-ones really means 100 % duty
  always_comb begin
    pwm_on    = (bri_sh_q == PWM_FULL) || (pwm_cnt_q < bri_sh_q);
    led_out_d = pat_sh_q & {10{pwm_on & ~(ben_sh_q & blink_phase_q)}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q        <= 16'd0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
      pat_sh_q       <= 10'd0;
      bri_sh_q       <= '0;
      ben_sh_q       <= 1'b0;
      blink_cnt_q    <= 16'd0;
      blink_phase_q  <= 1'b0;
      led_out_q      <= 10'd0;
    end else begin
      presc_q        <= presc_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
      pat_sh_q       <= pat_sh_d;
      bri_sh_q       <= bri_sh_d;
      ben_sh_q       <= ben_sh_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      led_out_q      <= led_out_d;
    end
  end

  assign led_out      = led_out_q;
  assign period_start = period_start_q;
  assign blink_phase  = blink_phase_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with PWM_BITS=4, PRESCALE=2, BLINK_TICKS=2 (32-clock period).
// Expected waveforms are hand-derived cycle counts since reset release.
module tb_led_pwm_driver;

  logic       clk;
  logic       reset;
  logic [9:0] led_pattern;
  logic [3:0] brightness;
  logic       blink_en;
  logic [9:0] led_out;
  logic       period_start;
  logic       blink_phase;

  int n_checks = 0;
  int n_errors = 0;
  int k        = 0;

  led_pwm_driver #(
    .PWM_BITS   (4),
    .PRESCALE   (2),
    .BLINK_TICKS(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .led_pattern (led_pattern),
    .brightness  (brightness),
    .blink_en    (blink_en),
    .led_out     (led_out),
    .period_start(period_start),
    .blink_phase (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; led_out must hold exp_led, period_start must pulse on k%32==31
  task automatic step_led(input int n, input logic [9:0] exp_led);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
      chk($sformatf("led_out@%0d", k), 32'(led_out), 32'(exp_led));
      chk($sformatf("period_start@%0d", k), 32'(period_start), 32'((k % 32) == 31));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_led"},   32'(led_out),      32'h0);
    chk({tag, "_ps"},    32'(period_start), 32'h0);
    chk({tag, "_phase"}, 32'(blink_phase),  32'h0);
  endtask

  initial begin
    reset       = 1'b1;
    led_pattern = 10'h3FF;
    brightness  = 4'hF;
    blink_en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst");
    reset = 1'b0;
    k     = 0;

    // Full-on pattern: dark until first boundary load, then constant
    step_led(32, 10'h000);
    step_led(32, 10'h3FF);

    // Duty 4/16: 8 clocks on, 24 off
    led_pattern = 10'h155;
    brightness  = 4'd4;
    step_led(32, 10'h3FF);
    step_led(8,  10'h155);
    step_led(24, 10'h000);
    step_led(8,  10'h155);
    step_led(4,  10'h000);

    // Mid-period brightness change only lands at the next boundary
    brightness = 4'd12;
    step_led(20, 10'h000);
    step_led(24, 10'h155);
    step_led(8,  10'h000);
    step_led(8,  10'h155);

    // Blink enable with full brightness
    led_pattern = 10'h201;
    brightness  = 4'hF;
    blink_en    = 1'b1;
    step_led(16, 10'h155);
    step_led(8,  10'h000);
    chk("phase@224", 32'(blink_phase), 32'h0);
    step_led(31, 10'h201);
    chk("phase@255", 32'(blink_phase), 32'h0);
    step_led(1,  10'h201);
    chk("phase@256", 32'(blink_phase), 32'h1);
    step_led(64, 10'h000);
    chk("phase@320", 32'(blink_phase), 32'h0);
    step_led(64, 10'h201);
    chk("phase@384", 32'(blink_phase), 32'h1);
    step_led(16, 10'h000);

    // Disabling blink clears the phase at the loading boundary
    blink_en = 1'b0;
    step_led(16, 10'h000);
    chk("phase@416", 32'(blink_phase), 32'h0);
    step_led(32, 10'h201);

    // Zero brightness keeps everything dark
    led_pattern = 10'h3FF;
    brightness  = 4'd0;
    step_led(32, 10'h201);
    step_led(40, 10'h000);

    // Mid-period reset with new inputs that must be ignored while reset is high
    brightness = 4'hF;
    reset      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_reset_state($sformatf("midrst%0d", i));
    end
    reset = 1'b0;
    k     = 0;
    step_led(32, 10'h000);
    step_led(32, 10'h3FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
